// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
//   Single-car elevator sequencer using a SCAN (collective) policy.
//   Floor-button requests are latched into a pending mask. The car keeps
//   travelling in its current direction while requests lie ahead of it,
//   reverses when only requests behind it remain, and opens the door at
//   every floor that has a pending request. Floor-to-floor travel and door
//   dwell are each timed by a shared cycle counter.
//
// Ports
//   clk            in   1        clock, all state updated on posedge
//   rst            in   1        asynchronous active-high reset
//   buttons        in   FLOORS   level request per floor
//   current_floor  out  FLOOR_W  floor the car is at or last departed
//   door_open      out  1        door open (DOOR state)
//   moving         out  1        car travelling (MOVE state)
//   dir_up         out  1        sweep direction, 1 = up, 0 = down
//   pending        out  FLOORS   latched, unserved requests
// ---------------------------------------------------------------------------
module elevator_scheduler #(
    parameter int FLOORS        = 5,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  buttons,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               door_open,
    output logic               moving,
    output logic               dir_up,
    output logic [FLOORS-1:0]  pending
);

    // One timer serves both MOVE and DOOR, so it is sized for the longer.
    localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = (TMAX < 2) ? 1 : $clog2(TMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [FLOOR_W-1:0] floor_reg, floor_next;
    logic               dir_reg, dir_next;
    logic [FLOORS-1:0]  pending_reg, pending_next;

    // Per-floor position masks relative to the car.
    logic [FLOORS-1:0]  floor_hot;
    logic [FLOORS-1:0]  above_mask;
    logic [FLOORS-1:0]  below_mask;
    logic [FLOORS-1:0]  clr;
    logic               ahead;
    logic               behind;
    logic               here_req;
    logic               hold_req;

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_mask
            assign floor_hot[gi]  = (floor_reg == FLOOR_W'(gi));
            assign above_mask[gi] = (FLOOR_W'(gi) > floor_reg);
            assign below_mask[gi] = (FLOOR_W'(gi) < floor_reg);
        end
    endgenerate

    // The top/bottom floors have nothing beyond them, so a move is only ever
    // started toward an existing request and can never run off either end.
    assign ahead    = dir_reg ? |(pending_reg & above_mask) : |(pending_reg & below_mask);
    assign behind   = dir_reg ? |(pending_reg & below_mask) : |(pending_reg & above_mask);
    assign here_req = |(pending_reg & floor_hot);
    assign hold_req = |(buttons & floor_hot);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        floor_next = floor_reg;
        dir_next   = dir_reg;
        clr        = '0;
        case (state_reg)
            IDLE: begin
                if (here_req) begin
                    state_next = DOOR;
                    timer_next = '0;
                    clr        = floor_hot;
                end else if (ahead) begin
                    state_next = MOVE;
                    timer_next = '0;
                end else if (behind) begin
                    state_next = MOVE;
                    timer_next = '0;
                    dir_next   = ~dir_reg;
                end
            end
            MOVE: begin
                if (timer_reg == TIMER_W'(TRAVEL_CYCLES - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    floor_next = dir_reg ? floor_reg + FLOOR_W'(1) : floor_reg - FLOOR_W'(1);
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            DOOR: begin
                // A request for this floor while the door is open is served
                // immediately: it never latches, and it restarts the dwell.
                clr = floor_hot;
                if (hold_req) begin
                    timer_next = '0;
                end else if (timer_reg == TIMER_W'(DOOR_CYCLES - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        // Clear wins over a same-edge set of the floor being served.
        pending_next = (pending_reg | buttons) & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            floor_reg   <= '0;
            dir_reg     <= 1'b1;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            floor_reg   <= floor_next;
            dir_reg     <= dir_next;
            pending_reg <= pending_next;
        end
    end

    assign current_floor = floor_reg;
    assign door_open     = (state_reg == DOOR);
    assign moving        = (state_reg == MOVE);
    assign dir_up        = dir_reg;
    assign pending       = pending_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler with default parameters
//   (5 floors, 4 travel cycles, 3 door cycles). Inputs change and outputs
//   are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] buttons = '0;
    logic [2:0] current_floor;
    logic       door_open;
    logic       moving;
    logic       dir_up;
    logic [4:0] pending;

    int errors = 0;
    int checks = 0;
    int opens[$];

    elevator_scheduler #(
        .FLOORS(5), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buttons(buttons),
        .current_floor(current_floor),
        .door_open(door_open),
        .moving(moving),
        .dir_up(dir_up),
        .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        buttons = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Run n cycles, checking the invariants every cycle and logging the
    // floor at each door-open rising edge.
    task automatic run_log(input int n);
        logic prev_door;
        prev_door = door_open;
        for (int i = 0; i < n; i++) begin
            tick();
            check("door_and_moving", {31'd0, door_open & moving}, 32'd0);
            check("floor_in_range", {31'd0, (current_floor <= 3'd4)}, 32'd1);
            if (door_open && !prev_door) opens.push_back(int'(current_floor));
            prev_door = door_open;
        end
    endtask

    initial begin
        int exp_floor;
        int door_cycles;
        bit found;

        // ---------------- reset state
        do_reset();
        check("rst_floor", current_floor, 0);
        check("rst_door", door_open, 0);
        check("rst_moving", moving, 0);
        check("rst_dir", dir_up, 1);
        check("rst_pending", pending, 0);

        // ---------------- test 1: request at current floor
        buttons = 5'b00001;
        tick();
        buttons = '0;
        check("t1_latched", pending, 5'b00001);
        check("t1_door_pre", door_open, 0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            $display("t1 cycle %0d floor=%0d door=%0b pending=%b", n, current_floor, door_open, pending);
            check("t1_door", door_open, (n <= 3) ? 1 : 0);
            check("t1_pending", pending, 0);
            check("t1_floor", current_floor, 0);
        end

        // ---------------- test 2: travel 0 -> 3
        do_reset();
        buttons = 5'b01000;
        tick();
        buttons = '0;
        check("t2_latched", pending, 5'b01000);
        check("t2_moving_pre", moving, 0);
        for (int n = 1; n <= 19; n++) begin
            tick();
            exp_floor = (n < 5) ? 0 : (n < 10) ? 1 : (n < 15) ? 2 : 3;
            $display("t2 cycle %0d floor=%0d moving=%0b door=%0b", n, current_floor, moving, door_open);
            check("t2_floor", current_floor, exp_floor);
            check("t2_moving", moving, ((n < 15) && (n % 5 != 0)) ? 1 : 0);
            check("t2_door", door_open, ((n >= 16) && (n <= 18)) ? 1 : 0);
        end
        check("t2_dir", dir_up, 1);
        check("t2_pending", pending, 0);

        // ---------------- test 3: at floor 3 going up, requests {1,4}
        buttons = 5'b10010;
        tick();
        buttons = '0;
        check("t3_latched", pending, 5'b10010);
        opens.delete();
        run_log(35);
        $display("t3 stops=%p floor=%0d dir_up=%0b", opens, current_floor, dir_up);
        check("t3_nstops", opens.size(), 2);
        check("t3_stop0", (opens.size() > 0) ? opens[0] : -1, 4);
        check("t3_stop1", (opens.size() > 1) ? opens[1] : -1, 1);
        check("t3_dir", dir_up, 0);
        check("t3_floor", current_floor, 1);
        check("t3_pending", pending, 0);

        // ---------------- test 4: door held open at floor 2
        buttons = 5'b00100;
        tick();
        buttons = '0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (door_open) begin
                found = 1;
                break;
            end
        end
        check("t4_door_reached", found, 1);
        check("t4_floor", current_floor, 2);
        door_cycles = 1;
        buttons = 5'b00100;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_door_held", door_open, 1);
            check("t4_pend2_held", pending[2], 0);
            if (door_open) door_cycles++;
        end
        buttons = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_pend2_after", pending[2], 0);
            if (door_open) door_cycles++;
        end
        $display("t4 door_cycles=%0d", door_cycles);
        check("t4_door_cycles", door_cycles, 9);
        check("t4_dir", dir_up, 1);

        // ---------------- test 5: async reset mid-move between 2 and 3
        buttons = 5'b11000;
        tick();
        buttons = '0;
        tick();
        tick();
        check("t5_moving_pre", moving, 1);
        check("t5_floor_pre", current_floor, 2);
        check("t5_pending_pre", pending, 5'b11000);
        #2;
        rst = 1'b1;
        #1;
        $display("t5 async reset floor=%0d pending=%b moving=%0b door=%0b dir=%0b",
                 current_floor, pending, moving, door_open, dir_up);
        check("t5_floor", current_floor, 0);
        check("t5_pending", pending, 0);
        check("t5_moving", moving, 0);
        check("t5_door", door_open, 0);
        check("t5_dir", dir_up, 1);
        tick();
        rst = 1'b0;
        tick();
        check("t5_idle_after", {30'd0, moving, door_open}, 0);

        // ---------------- test 6: all five requests from floor 0
        buttons = 5'b11111;
        tick();
        buttons = '0;
        check("t6_latched", pending, 5'b11111);
        opens.delete();
        run_log(50);
        $display("t6 stops=%p floor=%0d", opens, current_floor);
        check("t6_nstops", opens.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t6_stop", (opens.size() > i) ? opens[i] : -1, i);
        end
        check("t6_floor", current_floor, 4);
        check("t6_pending", pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
